// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline register between core pipeline stages
//
// Carries a control field and a data payload across a stage boundary with a
// valid/ready handshake, a synchronous flush, and a saturating stall counter.
// Control bits read as zero whenever no valid entry is held, so the next stage
// always sees a clean bubble.
//
// Build option: define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a
// registered in_ready. Left undefined, the stage holds a single entry and
// in_ready is combinational from out_ready.
//
// Parameters:
//   CTRL_W     width of the control field
//   DATA_W     width of the data payload
//   CNT_W      width of the stall counter
// Ports:
//   clock      rising-edge clock
//   reset      synchronous, active-high reset
//   flush      discard all held and incoming entries this cycle
//   in_valid   upstream entry present
//   in_ready   stage can accept an entry this cycle
//   in_ctrl    upstream control field
//   in_data    upstream data payload
//   out_valid  entry presented downstream (flop output)
//   out_ready  downstream accepts entry
//   out_ctrl   control field, all zero while out_valid=0 (flop output)
//   out_data   data payload, holds last value while out_valid=0 (flop output)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0

module pipe_stage_reg #(
    parameter int CTRL_W = 10,
    parameter int DATA_W = 271,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q,  state_d;
    logic              valid_q,  valid_d;
    logic [CTRL_W-1:0] ctrl_q,   ctrl_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [CNT_W-1:0]  stall_q,  stall_d;

    logic accept;
    logic xfer;

    assign xfer   = valid_q && out_ready;
    assign accept = in_valid && in_ready;

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign stall_cnt = stall_q;

    // Saturating stall counter; flush does not clear it, only reset does.
    always_comb begin
        stall_d = stall_q;
        if (valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    logic              in_ready_q, in_ready_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;

    // in_ready comes straight from a flop so no path exists from out_ready.
    assign in_ready = in_ready_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        ctrl_d      = ctrl_q;
        data_d      = data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;

        if (flush) begin
            // Everything held or arriving this cycle is dropped; data keeps
            // its last value, only the control field is cleared.
            state_d = ST_EMPTY;
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        valid_d = 1'b1;
                        ctrl_d  = in_ctrl;
                        data_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (xfer && accept) begin
                        ctrl_d = in_ctrl;
                        data_d = in_data;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                        valid_d = 1'b0;
                        ctrl_d  = '0;
                    end else if (accept) begin
                        // Downstream stalled while we were still advertising
                        // ready: park the new entry behind the main one.
                        state_d     = ST_TWO;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so nothing can be accepted.
                    if (xfer) begin
                        state_d = ST_ONE;
                        ctrl_d  = skid_ctrl_q;
                        data_d  = skid_data_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    valid_d = 1'b0;
                    ctrl_d  = '0;
                end
            endcase
        end

        in_ready_d = (state_d != ST_TWO);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_EMPTY;
            valid_q     <= 1'b0;
            ctrl_q      <= '0;
            data_q      <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            data_q      <= data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
        end
    end

`else

    // Single entry: ready when empty or when the held entry leaves this cycle.
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;

        if (flush) begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        valid_d = 1'b1;
                        ctrl_d  = in_ctrl;
                        data_d  = in_data;
                    end
                end
                ST_ONE: begin
                    // accept implies xfer here because in_ready needs out_ready.
                    if (xfer && accept) begin
                        ctrl_d = in_ctrl;
                        data_d = in_data;
                    end else if (xfer) begin
                        state_d = ST_EMPTY;
                        valid_d = 1'b0;
                        ctrl_d  = '0;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    valid_d = 1'b0;
                    ctrl_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end

`endif

endmodule
